brute_force_matcher: RTL and testbench

Parametrised brute-force string matcher. It scans a text held in a synchronous-read ROM for every occurrence of a pattern held in a second ROM, and reports the occurrence count and the first match position. It supersedes the fixed-size pattern-search datapath: pattern length, text length, symbol width and counter width are runtime or parameter driven, overlapping matches are counted, and a start/done handshake is added. It sits between the text/pattern ROMs and the results/control logic.

---
 rtl/brute_force_matcher_if.sv | 31 +++
 rtl/brute_force_matcher.sv | 144 ++++++++++++++
 tb/tb_brute_force_matcher.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/brute_force_matcher_if.sv
// Bundle of the matcher's control, ROM and result signals.
// Master is the environment (ROMs, control); slave is the matcher.
interface brute_force_matcher_if #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned PAT_ADDR_W = 3,
   parameter int unsigned TXT_ADDR_W = 8,
   parameter int unsigned CNT_W      = 8
);
   logic                  start;
   logic [PAT_ADDR_W:0]   pat_len;
   logic [TXT_ADDR_W:0]   txt_len;
   logic [PAT_ADDR_W-1:0] pat_addr;
   logic [DATA_W-1:0]     pat_data;
   logic [TXT_ADDR_W-1:0] txt_addr;
   logic [DATA_W-1:0]     txt_data;
   logic                  busy;
   logic                  done;
   logic                  found;
   logic [CNT_W-1:0]      match_count;
   logic [TXT_ADDR_W-1:0] first_pos;

   modport master (
      output start, pat_len, txt_len, pat_data, txt_data,
      input  pat_addr, txt_addr, busy, done, found, match_count, first_pos
   );

   modport slave (
      input  start, pat_len, txt_len, pat_data, txt_data,
      output pat_addr, txt_addr, busy, done, found, match_count, first_pos
   );
endinterface

// File: rtl/brute_force_matcher.sv
// Brute-force search of a pattern ROM over a text ROM; counts overlapping matches.
// Optional STOP_ON_FIRST_EN: end the search at the first full match.
module brute_force_matcher #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned PAT_ADDR_W = 3,
   parameter int unsigned TXT_ADDR_W = 8,
   parameter int unsigned CNT_W      = 8
) (
   input logic                  i_clk,
   input logic                  i_rst,
   brute_force_matcher_if.slave io_bus
);

   localparam int unsigned PL_W = PAT_ADDR_W + 1;
   localparam int unsigned TL_W = TXT_ADDR_W + 1;

   typedef enum logic [1:0] {StIdle, StIssue, StCompare, StDone} state_e;

   state_e                r_state, w_state_nxt;
   logic [TL_W-1:0]       r_i, w_i_nxt;
   logic [PL_W-1:0]       r_j, w_j_nxt;
   logic [PL_W-1:0]       r_pat_len, w_pat_len_nxt;
   logic [TL_W-1:0]       r_txt_len, w_txt_len_nxt;
   logic [CNT_W-1:0]      r_count, w_count_nxt;
   logic                  r_found, w_found_nxt;
   logic [TXT_ADDR_W-1:0] r_first_pos, w_first_pos_nxt;
   logic [PAT_ADDR_W-1:0] r_pat_addr, w_pat_addr_nxt;
   logic [TXT_ADDR_W-1:0] r_txt_addr, w_txt_addr_nxt;

   logic                  w_sym_eq;
   logic                  w_last_sym;
   logic [TL_W-1:0]       w_last_start;
   logic                  w_last_win;
   logic                  w_degenerate;

   assign w_sym_eq     = (io_bus.pat_data == io_bus.txt_data);
   assign w_last_sym   = (r_j == (r_pat_len - PL_W'(1)));
   assign w_last_start = r_txt_len - TL_W'(r_pat_len);
   // i+1 > last_start is the same as i >= last_start, without the extra adder
   assign w_last_win   = (r_i >= w_last_start);
   assign w_degenerate = (io_bus.pat_len == '0) || (TL_W'(io_bus.pat_len) > io_bus.txt_len);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_i         <= '0;
         r_j         <= '0;
         r_pat_len   <= '0;
         r_txt_len   <= '0;
         r_count     <= '0;
         r_found     <= 1'b0;
         r_first_pos <= '0;
         r_pat_addr  <= '0;
         r_txt_addr  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_i         <= w_i_nxt;
         r_j         <= w_j_nxt;
         r_pat_len   <= w_pat_len_nxt;
         r_txt_len   <= w_txt_len_nxt;
         r_count     <= w_count_nxt;
         r_found     <= w_found_nxt;
         r_first_pos <= w_first_pos_nxt;
         r_pat_addr  <= w_pat_addr_nxt;
         r_txt_addr  <= w_txt_addr_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_i_nxt         = r_i;
      w_j_nxt         = r_j;
      w_pat_len_nxt   = r_pat_len;
      w_txt_len_nxt   = r_txt_len;
      w_count_nxt     = r_count;
      w_found_nxt     = r_found;
      w_first_pos_nxt = r_first_pos;

      unique case (r_state)
         StIdle: begin
            if (io_bus.start) begin
               w_pat_len_nxt   = io_bus.pat_len;
               w_txt_len_nxt   = io_bus.txt_len;
               w_i_nxt         = '0;
               w_j_nxt         = '0;
               w_count_nxt     = '0;
               w_found_nxt     = 1'b0;
               w_first_pos_nxt = '0;
               w_state_nxt     = w_degenerate ? StDone : StIssue;
            end
         end
         StIssue: begin
            w_state_nxt = StCompare;
         end
         StCompare: begin
            if (w_sym_eq && !w_last_sym) begin
               w_j_nxt     = r_j + PL_W'(1);
               w_state_nxt = StIssue;
            end else begin
               if (w_sym_eq) begin
                  if (!(&r_count)) begin
                     w_count_nxt = r_count + CNT_W'(1);
                  end
                  if (!r_found) begin
                     w_found_nxt     = 1'b1;
                     w_first_pos_nxt = TXT_ADDR_W'(r_i);
                  end
               end
               // Window slides by one symbol, so overlapping matches are seen
               w_j_nxt     = '0;
               w_i_nxt     = r_i + TL_W'(1);
               w_state_nxt = w_last_win ? StDone : StIssue;
`ifdef STOP_ON_FIRST_EN
               if (w_sym_eq) begin
                  w_state_nxt = StDone;
               end
`endif
            end
         end
         StDone: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // ROM addresses load on entry to ISSUE so data is valid during COMPARE
   always_comb begin
      w_pat_addr_nxt = r_pat_addr;
      w_txt_addr_nxt = r_txt_addr;
      if (w_state_nxt == StIssue) begin
         w_pat_addr_nxt = PAT_ADDR_W'(w_j_nxt);
         w_txt_addr_nxt = TXT_ADDR_W'(w_i_nxt + TL_W'(w_j_nxt));
      end
   end

   assign io_bus.pat_addr    = r_pat_addr;
   assign io_bus.txt_addr    = r_txt_addr;
   assign io_bus.busy        = (r_state == StIssue) || (r_state == StCompare);
   assign io_bus.done        = (r_state == StDone);
   assign io_bus.found       = r_found;
   assign io_bus.match_count = r_count;
   assign io_bus.first_pos   = r_first_pos;

endmodule

// File: tb/tb_brute_force_matcher.sv
// Directed bench for brute_force_matcher: two instances (CNT_W=8 and CNT_W=4).
module tb_brute_force_matcher;

   localparam int unsigned DW  = 8;
   localparam int unsigned PAW = 3;
   localparam int unsigned TAW = 8;

`ifdef STOP_ON_FIRST_EN
   localparam int S1_CNT = 1;
   localparam int S1_CYC = 7;
   localparam int SAT_CNT = 1;
   localparam int SAT_CYC = 3;
`else
   localparam int S1_CNT = 2;
   localparam int S1_CYC = 17;
   localparam int SAT_CNT = 15;
   localparam int SAT_CYC = 511;
`endif

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [DW-1:0] pat_rom [8];
   logic [DW-1:0] txt_rom [256];

   brute_force_matcher_if #(.DATA_W(DW), .PAT_ADDR_W(PAW), .TXT_ADDR_W(TAW), .CNT_W(8)) b0 ();
   brute_force_matcher_if #(.DATA_W(DW), .PAT_ADDR_W(PAW), .TXT_ADDR_W(TAW), .CNT_W(4)) b1 ();

   brute_force_matcher #(.DATA_W(DW), .PAT_ADDR_W(PAW), .TXT_ADDR_W(TAW), .CNT_W(8)) u_dut0 (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (b0)
   );

   brute_force_matcher #(.DATA_W(DW), .PAT_ADDR_W(PAW), .TXT_ADDR_W(TAW), .CNT_W(4)) u_dut1 (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read ROMs, one cycle of latency
   always_ff @(posedge clk) begin
      b0.pat_data <= pat_rom[b0.pat_addr];
      b0.txt_data <= txt_rom[b0.txt_addr];
      b1.pat_data <= pat_rom[b1.pat_addr];
      b1.txt_data <= txt_rom[b1.txt_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic load(input string t, input string p);
      for (int k = 0; k < 256; k++) txt_rom[k] = '0;
      for (int k = 0; k < 8; k++) pat_rom[k] = '0;
      for (int k = 0; k < t.len(); k++) txt_rom[k] = t[k];
      for (int k = 0; k < p.len(); k++) pat_rom[k] = p[k];
   endtask

   // Returns the cycle (counted from the accepting edge) in which done is seen
   task automatic run(input bit sel, input int pl, input int tl, output int cyc);
      @(negedge clk);
      if (!sel) begin
         b0.start = 1'b1; b0.pat_len = 4'(pl); b0.txt_len = 9'(tl);
      end else begin
         b1.start = 1'b1; b1.pat_len = 4'(pl); b1.txt_len = 9'(tl);
      end
      @(posedge clk);
      @(negedge clk);
      b0.start = 1'b0;
      b1.start = 1'b0;
      cyc = 1;
      while (!(sel ? b1.done : b0.done) && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   initial begin
      int cyc;
      int seen;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      b0.start = 1'b0; b0.pat_len = '0; b0.txt_len = '0;
      b1.start = 1'b0; b1.pat_len = '0; b1.txt_len = '0;
      load("", "");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      check("rst_busy", 32'(b0.busy), 0);
      check("rst_done", 32'(b0.done), 0);
      check("rst_found", 32'(b0.found), 0);
      check("rst_count", 32'(b0.match_count), 0);
      check("rst_first", 32'(b0.first_pos), 0);
      check("rst_pat_addr", 32'(b0.pat_addr), 0);
      check("rst_txt_addr", 32'(b0.txt_addr), 0);

      // ABABAB / ABA: overlapping matches at 0 and 2
      load("ABABAB", "ABA");
      run(1'b0, 3, 6, cyc);
      check("s1_cycle", 32'(cyc), S1_CYC);
      check("s1_count", 32'(b0.match_count), S1_CNT);
      check("s1_found", 32'(b0.found), 1);
      check("s1_first", 32'(b0.first_pos), 0);
      check("s1_busy_in_done", 32'(b0.busy), 0);
      @(negedge clk);
      check("s1_done_pulse", 32'(b0.done), 0);
      check("s1_count_hold", 32'(b0.match_count), S1_CNT);

      // pat_len = 0 clears earlier results, finishes at once
      run(1'b0, 0, 6, cyc);
      check("p0_cycle", 32'(cyc), 1);
      check("p0_count", 32'(b0.match_count), 0);
      check("p0_found", 32'(b0.found), 0);
      check("p0_busy", 32'(b0.busy), 0);

      // pat_len > txt_len
      run(1'b0, 5, 3, cyc);
      check("plong_cycle", 32'(cyc), 1);
      check("plong_count", 32'(b0.match_count), 0);

      // No match: 6 windows of one comparison each
      load("XYZXYZ", "Q");
      run(1'b0, 1, 6, cyc);
      check("q_cycle", 32'(cyc), 13);
      check("q_count", 32'(b0.match_count), 0);
      check("q_found", 32'(b0.found), 0);
      check("q_first", 32'(b0.first_pos), 0);

      // Counter saturation on the 4-bit instance
      for (int k = 0; k < 256; k++) txt_rom[k] = (k < 255) ? 8'h41 : 8'h00;
      for (int k = 0; k < 8; k++) pat_rom[k] = (k == 0) ? 8'h41 : 8'h00;
      run(1'b1, 1, 255, cyc);
      check("sat_cycle", 32'(cyc), SAT_CYC);
      check("sat_count", 32'(b1.match_count), SAT_CNT);
      check("sat_found", 32'(b1.found), 1);
      check("sat_first", 32'(b1.first_pos), 0);

      // Reset during the 3rd COMPARE (cycle 6) of the ABABAB search
      load("ABABAB", "ABA");
      @(negedge clk);
      b0.start = 1'b1; b0.pat_len = 4'd3; b0.txt_len = 9'd6;
      @(posedge clk);
      @(negedge clk);
      b0.start = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_mid_busy_before", 32'(b0.busy), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_busy", 32'(b0.busy), 0);
      check("rst_mid_done", 32'(b0.done), 0);
      check("rst_mid_found", 32'(b0.found), 0);
      check("rst_mid_count", 32'(b0.match_count), 0);
      check("rst_mid_txt_addr", 32'(b0.txt_addr), 0);
      check("rst_mid_pat_addr", 32'(b0.pat_addr), 0);
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (b0.done || b0.busy) seen = 1;
      end
      check("rst_mid_no_done", 32'(seen), 0);
      run(1'b0, 3, 6, cyc);
      check("rerun_cycle", 32'(cyc), S1_CYC);
      check("rerun_count", 32'(b0.match_count), S1_CNT);
      check("rerun_first", 32'(b0.first_pos), 0);

      // Extra start while busy (cycle 3) and while in DONE are ignored
      @(negedge clk);
      b0.start = 1'b1; b0.pat_len = 4'd3; b0.txt_len = 9'd6;
      @(posedge clk);
      @(negedge clk);
      b0.start = 1'b0;
      cyc = 1;
      while (!b0.done && cyc < 2000) begin
         b0.start = (cyc == 3);
         @(negedge clk);
         cyc++;
      end
      b0.start = 1'b1;
      check("busy_start_cycle", 32'(cyc), S1_CYC);
      check("busy_start_count", 32'(b0.match_count), S1_CNT);
      @(negedge clk);
      b0.start = 1'b0;
      check("done_start_busy", 32'(b0.busy), 0);
      @(negedge clk);
      check("done_start_busy2", 32'(b0.busy), 0);
      check("done_start_count", 32'(b0.match_count), S1_CNT);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
